// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: divider width and divider FSM encoding,
// exposed so the execute-stage HI/LO controller can decode divider status.
package mips_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial
// subtract the divisor magnitude, keep the difference when no borrow occurs.
module div_step
   import mips_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             q_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   sub_b;
   logic [WIDTH:0]   diff;
   logic [WIDTH+1:0] carry;
   logic             unused_top;

   assign shifted  = {rem, q_in};
   assign sub_b    = ~{1'b0, divisor};
   assign carry[0] = 1'b1;

   // Subtract by adding the inverted divisor with carry-in 1; carry out set means no borrow.
   for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
      full_adder u_fa (
         .a    (shifted[i]),
         .b    (sub_b[i]),
         .cin  (carry[i]),
         .sum  (diff[i]),
         .cout (carry[i+1])
      );
   end

   assign q_bit    = carry[WIDTH+1];
   assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

   // The selected remainder is always below the divisor, so its top bit is zero.
   assign unused_top = diff[WIDTH] ^ shifted[WIDTH];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the divider subtractor.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mips_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// followed by a sign-fix cycle that registers quotient (LO) and remainder (HI).
module mips_divider
   import mips_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int              CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   div_state_e       state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvsr_mag;
   logic [WIDTH-1:0] dvd_orig;
   logic             neg_quo;
   logic             neg_rem;
   logic             dvsr_zero;

   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;
   logic [WIDTH-1:0] fix_quo;
   logic [WIDTH-1:0] fix_rem;

   assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

   // Quotient register doubles as the dividend shifter: its MSB feeds each step.
   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .q_in     (quo_q[WIDTH-1]),
      .divisor  (dvsr_mag),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

   // Divide-by-zero bypasses the sign fix and reports the original dividend.
   assign fix_quo = dvsr_zero ? '1       : (neg_quo ? -quo_q : quo_q);
   assign fix_rem = dvsr_zero ? dvd_orig : (neg_rem ? -rem_q : rem_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         count       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvsr_mag    <= '0;
         dvd_orig    <= '0;
         neg_quo     <= 1'b0;
         neg_rem     <= 1'b0;
         dvsr_zero   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rem_q     <= '0;
                  quo_q     <= dvd_mag;
                  dvsr_mag  <= dvs_mag;
                  dvd_orig  <= dividend;
                  neg_quo   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  neg_rem   <= is_signed & dividend[WIDTH-1];
                  dvsr_zero <= (divisor == '0);
                  count     <= LAST;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               rem_q <= step_rem;
               quo_q <= {quo_q[WIDTH-2:0], step_q};
               if (count == '0) begin
                  state <= FIX;
               end else begin
                  count <= count - 1'b1;
               end
            end
            FIX: begin
               quotient    <= fix_quo;
               remainder   <= fix_rem;
               div_by_zero <= dvsr_zero;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
